// File: rtl/ins_prefetch_buf.sv
// ins_prefetch_buf: sequential instruction prefetch FIFO between the core fetch port and a req/gnt memory bus.
// Define INS_PFB_STATS_EN to add saturating hit/redirect counters (stat_hit, stat_redirect).
module ins_prefetch_buf #(
  parameter int DEPTH = 4,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          exIns_ren,
  input  logic [AW-1:0] exIns_addr,
  output logic          exIns_valid,
  output logic [31:0]   exIns_in,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
`ifdef INS_PFB_STATS_EN
  ,
  output logic [31:0]   stat_hit,
  output logic [31:0]   stat_redirect
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d, infl_q, infl_d, disc_q, disc_d, total;
  logic [AW-1:0] pf_q, pf_d, old_addr, exp_addr;
  logic          empty, redirect, hit, gnt, push, drop;

  // Inflight words are always the contiguous run just below pf_q.
  assign empty    = count_q == '0;
  assign old_addr = pf_q - (AW'(infl_q) << 2);
  assign exp_addr = !empty ? addr_q[rd_q] : (infl_q != '0 ? old_addr : pf_q);
  assign redirect = exIns_ren && (state_q == IDLE || exIns_addr != exp_addr);
  assign hit      = exIns_ren && !redirect && !empty;

  assign exIns_valid = hit;
  assign exIns_in    = hit ? data_q[rd_q] : '0;
  // Stale words still owed by memory count against the cap so discard never exceeds DEPTH.
  assign mem_req  = state_q == STREAM && !redirect && (count_q + infl_q + disc_q) < CW'(DEPTH);
  assign mem_addr = pf_q;

  assign gnt   = mem_req && mem_gnt;
  assign drop  = mem_rvalid && disc_q != '0;
  assign push  = mem_rvalid && disc_q == '0 && infl_q != '0;
  assign total = disc_q + infl_q;

  assign state_d = (state_q == IDLE && exIns_ren) ? STREAM : state_q;
  assign rd_d    = redirect ? '0 : rd_q + PW'(hit);
  assign wr_d    = redirect ? '0 : wr_q + PW'(push);
  assign count_d = redirect ? '0 : count_q + CW'(push) - CW'(hit);
  assign infl_d  = redirect ? '0 : infl_q + CW'(gnt) - CW'(push);
  assign disc_d  = redirect ? total - CW'(mem_rvalid && total != '0) : disc_q - CW'(drop);
  assign pf_d    = redirect ? exIns_addr : pf_q + (gnt ? AW'(4) : '0);

  always_ff @(posedge clk) begin
    if (push && !redirect) begin
      addr_q[wr_q] <= old_addr;
      data_q[wr_q] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      infl_q  <= '0;
      disc_q  <= '0;
      pf_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      infl_q  <= infl_d;
      disc_q  <= disc_d;
      pf_q    <= pf_d;
    end
  end

`ifdef INS_PFB_STATS_EN
  logic [31:0] hit_q, redir_q;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hit_q   <= '0;
      redir_q <= '0;
    end else begin
      hit_q   <= hit_q + 32'(hit && hit_q != '1);
      redir_q <= redir_q + 32'(redirect && redir_q != '1);
    end
  end
  assign stat_hit      = hit_q;
  assign stat_redirect = redir_q;
`else
  // Counters compiled out; the stat ports do not exist in this build.
`endif

  a_rvalid_expected: assert property (@(posedge clk) disable iff (!nrst)
    mem_rvalid |-> (infl_q != '0 || disc_q != '0));
  a_addr_aligned: assert property (@(posedge clk) disable iff (!nrst)
    exIns_ren |-> exIns_addr[1:0] == 2'b00);
endmodule
